// File: rtl/cycle_walker_if.sv
// ---------------------------------------------------------------------------
// cycle_walker_if
//   Bundles the two bus-style connections of cycle_walker:
//     * vertex-memory read port : vm_addr (walker -> memory),
//                                 vm_q    (memory -> walker, 1-cycle latency)
//     * cycle vertex stream     : out_valid / out_vert / out_last (walker ->
//                                 consumer), out_ready (consumer -> walker)
//   master modport : the walker side.
//   slave modport  : the memory / downstream consumer side.
// ---------------------------------------------------------------------------
interface cycle_walker_if #(
  parameter int ADDR_W  = 4,
  parameter int ENTRY_W = 36
);
  logic [ADDR_W-1:0]  vm_addr;
  logic [ENTRY_W-1:0] vm_q;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_vert;
  logic               out_last;

  modport master (
    output vm_addr,
    input  vm_q,
    output out_valid,
    input  out_ready,
    output out_vert,
    output out_last
  );

  modport slave (
    input  vm_addr,
    output vm_q,
    input  out_valid,
    output out_ready,
    input  out_vert,
    input  out_last
  );
endinterface

// File: rtl/cycle_walker.sv
// ---------------------------------------------------------------------------
// cycle_walker
//   Walks the predecessor pointers left in the vertex memory by the
//   Bellman-Ford / cycle-detect container and streams the vertices of the
//   negative (arbitrage) cycle over a valid/ready port, then reports the
//   cycle length.
//
//   Operation:
//     1. Rewind: follow pred NUM_VERTS times from start_vert. Whatever vertex
//        is reached is guaranteed to sit on the cycle; it becomes the anchor.
//     2. Trace: for every cycle vertex, read its pred first, then emit it,
//        so out_last (pred == anchor) is known at emission time.
//     3. One cycle after the last handshake, done pulses with cyc_len.
//
//   Optional feature (macro CYCLE_TRADE_ORDER_EN):
//     Traced vertices are pushed into a NUM_VERTS-deep LIFO and popped after
//     the cycle closes, giving trade order (pred -> succ followed forward);
//     the anchor is popped last and carries out_last.
//     With the macro undefined vertices stream in predecessor order.
//
//   Ports:
//     clk        : clock
//     reset      : synchronous, active-high reset
//     start      : one-cycle pulse, begin a walk (ignored while busy and in
//                  the done cycle)
//     start_vert : flagged vertex, sampled when start is accepted
//     bus        : cycle_walker_if.master (vm_addr/vm_q read port,
//                  out_valid/out_ready/out_vert/out_last stream)
//     busy       : walk in progress
//     done       : one-cycle pulse after the final handshake
//     cyc_len    : cycle length, valid with done, held until next start
// ---------------------------------------------------------------------------
module cycle_walker #(
  parameter int ADDR_W   = 4,
  parameter int ENTRY_W  = 36,
  parameter int PRED_LSB = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_vert,
  cycle_walker_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   cyc_len
);

  localparam int NUM_VERTS = 2 ** ADDR_W;
  // Highest value of the rewind step counter; the pred read at this step is
  // the NUM_VERTS-th one.
  localparam logic [ADDR_W:0] STEP_LAST = (ADDR_W + 1)'(NUM_VERTS - 1);
  // Traced-vertex count at which the current vertex would be the
  // NUM_VERTS-th one; closure is forced there to survive corrupt pred data.
  localparam logic [ADDR_W:0] LEN_SAT   = (ADDR_W + 1)'(NUM_VERTS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RW_RD   = 3'd1,
    RW_WAIT = 3'd2,
    TR_RD   = 3'd3,
    TR_WAIT = 3'd4,
    EMIT    = 3'd5,
    FIN     = 3'd6
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] cur_r;
  logic [ADDR_W-1:0] anchor_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   step_r;
  logic [ADDR_W-1:0] vm_addr_r;
  logic              out_valid_r;
  logic [ADDR_W-1:0] out_vert_r;
  logic              out_last_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W:0]   cyc_len_r;

`ifdef CYCLE_TRADE_ORDER_EN
  // LIFO of traced vertices (all except the closing one, which is emitted
  // straight away as the first pop).
  logic [ADDR_W-1:0] lifo_r [NUM_VERTS];
  logic [ADDR_W-1:0] sp_r;
  logic [ADDR_W-1:0] sp_dec_s;
`else
  // pred of the vertex being emitted; becomes cur after the handshake.
  logic [ADDR_W-1:0] nxt_r;
`endif

  logic [ADDR_W-1:0] pred_s;
  logic              close_s;

  assign pred_s  = bus.vm_q[PRED_LSB +: ADDR_W];
  assign close_s = (pred_s == anchor_r) || (len_r == LEN_SAT);

`ifdef CYCLE_TRADE_ORDER_EN
  assign sp_dec_s = sp_r - ADDR_W'(1);
`endif

  assign bus.vm_addr   = vm_addr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_vert  = out_vert_r;
  assign bus.out_last  = out_last_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign cyc_len       = cyc_len_r;

  // Walker FSM: rewind, trace, emit, and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cur_r       <= '0;
      anchor_r    <= '0;
      len_r       <= '0;
      step_r      <= '0;
      vm_addr_r   <= '0;
      out_valid_r <= 1'b0;
      out_vert_r  <= '0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cyc_len_r   <= '0;
`ifdef CYCLE_TRADE_ORDER_EN
      sp_r        <= '0;
      for (int i = 0; i < NUM_VERTS; i++) begin
        lifo_r[i] <= '0;
      end
`else
      nxt_r       <= '0;
`endif
    end else begin
      // done is a single-cycle pulse; only the final handshake raises it.
      done_r <= 1'b0;

      case (state_r)
        IDLE: begin
          if (start) begin
            cur_r     <= start_vert;
            vm_addr_r <= start_vert;
            step_r    <= '0;
            busy_r    <= 1'b1;
            state_r   <= RW_RD;
          end else begin
            state_r   <= IDLE;
          end
        end

        // vm_addr already holds cur; memory answers next cycle.
        RW_RD: begin
          state_r <= RW_WAIT;
        end

        RW_WAIT: begin
          cur_r     <= pred_s;
          vm_addr_r <= pred_s;
          step_r    <= step_r + (ADDR_W + 1)'(1);
          if (step_r == STEP_LAST) begin
            // After NUM_VERTS steps cur is on the cycle: fix the anchor.
            anchor_r <= pred_s;
            len_r    <= '0;
`ifdef CYCLE_TRADE_ORDER_EN
            sp_r     <= '0;
`endif
            state_r  <= TR_RD;
          end else begin
            state_r  <= RW_RD;
          end
        end

        TR_RD: begin
          state_r <= TR_WAIT;
        end

`ifdef CYCLE_TRADE_ORDER_EN
        TR_WAIT: begin
          len_r <= len_r + (ADDR_W + 1)'(1);
          if (close_s) begin
            // Closing vertex is the top of the trade-order stream; the
            // anchor sits at the bottom of the LIFO (or is cur itself).
            out_valid_r <= 1'b1;
            out_vert_r  <= cur_r;
            out_last_r  <= (sp_r == '0);
            state_r     <= EMIT;
          end else begin
            lifo_r[sp_r] <= cur_r;
            sp_r         <= sp_r + ADDR_W'(1);
            cur_r        <= pred_s;
            vm_addr_r    <= pred_s;
            state_r      <= TR_RD;
          end
        end

        EMIT: begin
          if (bus.out_ready) begin
            if (out_last_r) begin
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              cyc_len_r   <= len_r;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= FIN;
            end else begin
              out_vert_r  <= lifo_r[sp_dec_s];
              out_last_r  <= (sp_r == ADDR_W'(1));
              sp_r        <= sp_dec_s;
              state_r     <= EMIT;
            end
          end else begin
            state_r <= EMIT;
          end
        end
`else
        TR_WAIT: begin
          nxt_r       <= pred_s;
          out_valid_r <= 1'b1;
          out_vert_r  <= cur_r;
          out_last_r  <= close_s;
          state_r     <= EMIT;
        end

        EMIT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            len_r       <= len_r + (ADDR_W + 1)'(1);
            if (out_last_r) begin
              out_last_r <= 1'b0;
              cyc_len_r  <= len_r + (ADDR_W + 1)'(1);
              done_r     <= 1'b1;
              busy_r     <= 1'b0;
              state_r    <= FIN;
            end else begin
              cur_r      <= nxt_r;
              vm_addr_r  <= nxt_r;
              state_r    <= TR_RD;
            end
          end else begin
            state_r <= EMIT;
          end
        end
`endif

        // done cycle: start is not sampled here.
        FIN: begin
          state_r <= IDLE;
        end

        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
